// File: rtl/board_line_clear_ctrl.sv
// Tetris playfield store with per-cell colour, registered read port and a sequential line-clear sweep.
// Define BOARD_TOPOUT_EN to register a spawn-zone (rows 0/1) occupancy flag at the end of each sweep.
module board_line_clear_ctrl #(
    parameter int unsigned COLS = 16,
    parameter int unsigned ROWS = 20,
    parameter int unsigned CW   = 3,
    parameter int unsigned XW   = 4,
    parameter int unsigned YW   = 5
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          WrEn,
    input  logic [XW-1:0] WrX,
    input  logic [YW-1:0] WrY,
    input  logic [CW-1:0] WrColor,
    input  logic [XW-1:0] RdX,
    input  logic [YW-1:0] RdY,
    output logic [CW-1:0] RdColor,
    input  logic          ClearStart,
    output logic          Busy,
    output logic          ClearDone,
    output logic [5:0]    LinesCleared,
    output logic [15:0]   TotalLines,
    output logic          TopOut
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ROWS-1:0][COLS-1:0][CW-1:0] board;
    logic [COLS-1:0][CW-1:0]           scan_row;
    logic [COLS-1:0]                   cell_set;
    logic [YW-1:0]                     r;
    logic [YW-1:0]                     k;
    logic [5:0]                        acc;
    logic [16:0]                       total_sum;
    logic                              row_full;
    logic                              wr_ok;
    logic                              rd_ok;

    // Row currently under the scan pointer; full when every cell holds a colour.
    assign scan_row = board[r];

    for (genvar c = 0; c < COLS; c++) begin : g_cell_set
        assign cell_set[c] = |scan_row[c];
    end

    assign row_full  = &cell_set;
    assign wr_ok     = WrEn && (state == S_IDLE) && (32'(WrX) < COLS) && (32'(WrY) < ROWS);
    assign rd_ok     = (32'(RdX) < COLS) && (32'(RdY) < ROWS);
    assign total_sum = {1'b0, TotalLines} + {11'b0, acc};

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (ClearStart) state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (row_full)       state_nxt = S_SHIFT;
                else if (r == '0)   state_nxt = S_DONE;
            end
            S_SHIFT: begin
                if (k <= YW'(1))    state_nxt = S_SCAN;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state != S_IDLE);
        ClearDone = (state == S_DONE);
    end

    // After a collapse r is left alone: the row that fell into r must be rescanned.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            board        <= '0;
            r            <= '0;
            k            <= '0;
            acc          <= '0;
            LinesCleared <= '0;
            TotalLines   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (wr_ok) board[WrY][WrX] <= WrColor;
                    if (ClearStart) begin
                        r   <= YW'(ROWS - 1);
                        acc <= '0;
                    end
                end
                S_SCAN: begin
                    if (row_full) begin
                        acc <= acc + 6'd1;
                        k   <= r;
                    end else if (r != '0) begin
                        r <= r - YW'(1);
                    end
                end
                S_SHIFT: begin
                    if (k == '0) begin
                        board[0] <= '0;
                    end else begin
                        board[k] <= board[k - YW'(1)];
                        if (k == YW'(1)) board[0] <= '0;
                        else             k <= k - YW'(1);
                    end
                end
                S_DONE: begin
                    LinesCleared <= acc;
                    TotalLines   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            RdColor <= '0;
        end else begin
            RdColor <= rd_ok ? board[RdY][RdX] : '0;
        end
    end

`ifdef BOARD_TOPOUT_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            TopOut <= 1'b0;
        end else if (state == S_DONE) begin
            TopOut <= (|board[0]) | (|board[1]);
        end
    end
`else
    assign TopOut = 1'b0;
`endif

endmodule

// File: tb/tb_board_line_clear_ctrl.sv
// Self-checking bench for board_line_clear_ctrl: reference board model plus a scoreboard queue of expected outputs.
module tb_board_line_clear_ctrl;

    localparam int COLS = 16;
    localparam int ROWS = 20;
    localparam int CW   = 3;
    localparam int XW   = 4;
    localparam int YW   = 5;

`ifdef BOARD_TOPOUT_EN
    localparam bit TOPOUT_EN = 1'b1;
`else
    localparam bit TOPOUT_EN = 1'b0;
`endif

    logic          Clock;
    logic          Resetn;
    logic          WrEn;
    logic [XW-1:0] WrX;
    logic [YW-1:0] WrY;
    logic [CW-1:0] WrColor;
    logic [XW-1:0] RdX;
    logic [YW-1:0] RdY;
    logic [CW-1:0] RdColor;
    logic          ClearStart;
    logic          Busy;
    logic          ClearDone;
    logic [5:0]    LinesCleared;
    logic [15:0]   TotalLines;
    logic          TopOut;

    board_line_clear_ctrl #(
        .COLS(COLS),
        .ROWS(ROWS),
        .CW  (CW),
        .XW  (XW),
        .YW  (YW)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .WrEn        (WrEn),
        .WrX         (WrX),
        .WrY         (WrY),
        .WrColor     (WrColor),
        .RdX         (RdX),
        .RdY         (RdY),
        .RdColor     (RdColor),
        .ClearStart  (ClearStart),
        .Busy        (Busy),
        .ClearDone   (ClearDone),
        .LinesCleared(LinesCleared),
        .TotalLines  (TotalLines),
        .TopOut      (TopOut)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int          mdl [ROWS][COLS];
    int unsigned total_exp;
    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned sb_exp[$];
    string       sb_tag[$];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input int unsigned v);
        sb_tag.push_back(tag);
        sb_exp.push_back(v);
    endtask

    task automatic sb_pop_check(input int unsigned got);
        string       tag;
        int unsigned exp;
        if (sb_exp.size() == 0) begin
            check("sb_underflow", 32'(sb_exp.size()), 1);
            return;
        end
        tag = sb_tag.pop_front();
        exp = sb_exp.pop_front();
        check(tag, got, exp);
    endtask

    function automatic int model_cell(input int x, input int y);
        if (x >= 0 && x < COLS && y >= 0 && y < ROWS) return mdl[y][x];
        return 0;
    endfunction

    task automatic clear_model();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) mdl[y][x] = 0;
    endtask

    task automatic do_write(input int x, input int y, input int c);
        WrEn    = 1'b1;
        WrX     = XW'(x);
        WrY     = YW'(y);
        WrColor = CW'(c);
        @(posedge Clock);
        #1;
        WrEn = 1'b0;
        if (x < COLS && y < ROWS) mdl[y][x] = c;
    endtask

    task automatic read_one(input int x, input int y, input string tag);
        RdX = XW'(x);
        RdY = YW'(y);
        sb_push(tag, 32'(model_cell(x, y)));
        @(posedge Clock);
        #1;
        sb_pop_check(32'(RdColor));
    endtask

    task automatic check_board(input string tag);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                read_one(x, y, $sformatf("%s_rd_x%0d_y%0d", tag, x, y));
    endtask

    task automatic fill_row(input int y, input int c);
        for (int x = 0; x < COLS; x++) do_write(x, y, c);
    endtask

    // Expected result comes from a filter-and-compact of the model; latency from the closed-form cost.
    task automatic run_sweep(input string tag, input bit with_write, input int wx, input int wy,
                             input int wc, input bit busy_poke);
        int full_rows[$];
        int nb [ROWS][COLS];
        int cycles;
        int dst;
        int cnt;
        int done_cnt;
        bit last_done;
        bit full;
        bit top;

        if (with_write && wx < COLS && wy < ROWS) mdl[wy][wx] = wc;

        for (int y = ROWS - 1; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < COLS; x++) if (mdl[y][x] == 0) full = 1'b0;
            if (full) full_rows.push_back(y);
        end
        cycles = ROWS + 1;
        foreach (full_rows[i]) begin
            int pos;
            pos = full_rows[i] + i;
            cycles += 1 + ((pos == 0) ? 1 : pos);
        end
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) nb[y][x] = 0;
        dst = ROWS - 1;
        for (int y = ROWS - 1; y >= 0; y--) begin
            full = 1'b0;
            foreach (full_rows[i]) if (full_rows[i] == y) full = 1'b1;
            if (!full) begin
                for (int x = 0; x < COLS; x++) nb[dst][x] = mdl[y][x];
                dst--;
            end
        end
        mdl = nb;
        top = 1'b0;
        for (int x = 0; x < COLS; x++) if (mdl[0][x] != 0 || mdl[1][x] != 0) top = 1'b1;
        total_exp = total_exp + 32'(full_rows.size());
        if (total_exp > 32'hFFFF) total_exp = 32'hFFFF;

        sb_push({tag, "_busy_cycles"}, 32'(cycles));
        sb_push({tag, "_done_pulses"}, 1);
        sb_push({tag, "_done_last"}, 1);
        sb_push({tag, "_lines"}, 32'(full_rows.size()));
        sb_push({tag, "_total"}, total_exp);
        sb_push({tag, "_topout"}, 32'(TOPOUT_EN & top));

        ClearStart = 1'b1;
        if (with_write) begin
            WrEn    = 1'b1;
            WrX     = XW'(wx);
            WrY     = YW'(wy);
            WrColor = CW'(wc);
        end
        @(posedge Clock);
        #1;
        ClearStart = 1'b0;
        WrEn       = 1'b0;

        cnt       = 0;
        done_cnt  = 0;
        last_done = 1'b0;
        while (Busy === 1'b1 && cnt < 2000) begin
            cnt++;
            if (ClearDone === 1'b1) done_cnt++;
            last_done = (ClearDone === 1'b1);
            if (busy_poke && cnt == 3) begin
                WrEn       = 1'b1;
                WrX        = XW'(5);
                WrY        = YW'(5);
                WrColor    = CW'(7);
                ClearStart = 1'b1;
            end else if (busy_poke && cnt == 4) begin
                WrEn       = 1'b0;
                ClearStart = 1'b0;
            end
            @(posedge Clock);
            #1;
        end
        WrEn       = 1'b0;
        ClearStart = 1'b0;
        if (cnt >= 2000) check({tag, "_sweep_timeout"}, 32'(cnt), 0);

        sb_pop_check(32'(cnt));
        sb_pop_check(32'(done_cnt));
        sb_pop_check(32'(last_done));
        sb_pop_check(32'(LinesCleared));
        sb_pop_check(32'(TotalLines));
        sb_pop_check(32'(TopOut));
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        total_exp  = 0;
        Resetn     = 1'b0;
        WrEn       = 1'b0;
        WrX        = '0;
        WrY        = '0;
        WrColor    = '0;
        RdX        = '0;
        RdY        = '0;
        ClearStart = 1'b0;
        clear_model();
        #23;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;

        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(ClearDone), 0);
        check("rst_lines", 32'(LinesCleared), 0);
        check("rst_total", 32'(TotalLines), 0);
        check("rst_topout", 32'(TopOut), 0);
        check("rst_rdcolor", 32'(RdColor), 0);
        check_board("rst");

        do_write(4, 7, 5);
        read_one(4, 7, "wr_4_7_c5");
        do_write(4, 7, 0);
        read_one(4, 7, "wr_4_7_erase");
        do_write(4, 20, 6);
        read_one(4, 20, "rd_oor_y20");
        read_one(4, 31, "rd_oor_y31");
        do_write(15, 19, 6);
        read_one(15, 19, "wr_corner");
        do_write(15, 19, 0);
        check_board("oor_write");

        // Single bottom row, one piece above it; a write and a ClearStart are poked mid-sweep.
        fill_row(19, 2);
        do_write(0, 18, 3);
        run_sweep("one_line", 1'b0, 0, 0, 0, 1'b1);
        read_one(0, 19, "one_line_fell");
        read_one(5, 5, "busy_write_dropped");
        check_board("one_line");

        fill_row(19, 1);
        fill_row(18, 4);
        fill_row(10, 7);
        do_write(2, 5, 4);
        do_write(7, 14, 6);
        do_write(11, 9, 3);
        run_sweep("three_lines", 1'b0, 0, 0, 0, 1'b0);
        check_board("three_lines");

        for (int x = 0; x < COLS - 1; x++) do_write(x, 19, 1);
        run_sweep("same_cycle_wr", 1'b1, 15, 19, 1, 1'b0);
        check_board("same_cycle_wr");

        fill_row(0, 5);
        run_sweep("top_row", 1'b0, 0, 0, 0, 1'b0);
        check_board("top_row");

        fill_row(19, 5);
        ClearStart = 1'b1;
        @(posedge Clock);
        #1;
        ClearStart = 1'b0;
        repeat (5) @(posedge Clock);
        #1;
        Resetn = 1'b0;
        #1;
        check("midshift_busy", 32'(Busy), 0);
        check("midshift_done", 32'(ClearDone), 0);
        check("midshift_total", 32'(TotalLines), 0);
        check("midshift_lines", 32'(LinesCleared), 0);
        check("midshift_rdcolor", 32'(RdColor), 0);
        #1;
        Resetn = 1'b1;
        clear_model();
        total_exp = 0;
        @(posedge Clock);
        #1;
        check_board("after_reset");

        run_sweep("empty", 1'b0, 0, 0, 0, 1'b0);

        do_write(3, 1, 2);
        run_sweep("topout", 1'b0, 0, 0, 0, 1'b0);
        read_one(3, 1, "topout_cell_kept");

        check("sb_drained", 32'(sb_exp.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1);
    end

endmodule
